// File: rtl/ram4k_arbiter.sv
// ============================================================================
// Module   : ram4k_arbiter
// Purpose  : Shares one RAM4K between two requesters, one access per clock.
//            Define RAM4K_ARB_CLEAR_EN to fill the RAM with CLEAR_VALUE after reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram4k_arbiter #(
   parameter int              AW          = 12,
   parameter int              DW          = 16,
   parameter int              FIXED_PRIO  = 0,
   parameter logic [DW-1:0]   CLEAR_VALUE = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_in,
   output logic          ram_load,
   input  logic [DW-1:0] ram_out,
   output logic          busy
);

   logic          w_serve;
   logic          w_clearing;
   logic          r_prefer1;
   logic [AW-1:0] r_addr_hold;
   logic [DW-1:0] r_din_hold;

`ifdef RAM4K_ARB_CLEAR_EN
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   localparam logic [AW-1:0] c_LAST_ADDR = '1;
   localparam logic [AW-1:0] c_ONE       = {{(AW-1){1'b0}}, 1'b1};

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_clr_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CLEAR)
            r_clr_addr <= r_clr_addr + c_ONE;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_CLEAR && r_clr_addr == c_LAST_ADDR)
         w_state_nxt = ST_SERVE;
   end

   // Gate with reset so the outputs show reset values while reset is held.
   assign w_clearing = (r_state == ST_CLEAR) && !reset;
   assign w_serve    = (r_state == ST_SERVE) && !reset;
   assign busy       = (r_state == ST_CLEAR);
`else
   logic w_unused_clear;

   assign w_unused_clear = ^CLEAR_VALUE;
   assign w_clearing     = 1'b0;
   assign w_serve        = !reset;
   assign busy           = 1'b0;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (w_serve) begin
         if (req0 && req1) begin
            if (FIXED_PRIO != 0 || !r_prefer1)
               gnt0 = 1'b1;
            else
               gnt1 = 1'b1;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // Ungranted cycles keep presenting the last address/data to the RAM.
   always_comb begin
      ram_load    = 1'b0;
      ram_address = r_addr_hold;
      ram_in      = r_din_hold;
`ifdef RAM4K_ARB_CLEAR_EN
      if (w_clearing) begin
         ram_load    = 1'b1;
         ram_address = r_clr_addr;
         ram_in      = CLEAR_VALUE;
      end else
`endif
      if (gnt0) begin
         ram_load    = we0;
         ram_address = addr0;
         ram_in      = wdata0;
      end else if (gnt1) begin
         ram_load    = we1;
         ram_address = addr1;
         ram_in      = wdata1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prefer1   <= 1'b0;
         r_addr_hold <= '0;
         r_din_hold  <= '0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
      end else begin
         r_addr_hold <= ram_address;
         r_din_hold  <= ram_in;
         rvalid0     <= gnt0 && !we0;
         rvalid1     <= gnt1 && !we1;
         if (gnt0 && !we0)
            rdata0 <= ram_out;
         if (gnt1 && !we1)
            rdata1 <= ram_out;
         if (gnt0)
            r_prefer1 <= 1'b1;
         else if (gnt1)
            r_prefer1 <= 1'b0;
      end
   end

endmodule

`default_nettype wire
